// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - Front-end sequencer bundle: pipeline requests in, stall/flush controls and counters out.
interface fetch_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             trigger;
    logic             ext_stall;
    logic             load_use;
    logic             branch_taken_d;
    logic             halt_d;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             PCSrcD;
    logic             pc_restart;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] stall_count;

    // Sequencer side: consumes hazard/branch requests, drives the pipeline controls.
    modport master (
        input  trigger, ext_stall, load_use, branch_taken_d, halt_d,
        output StallF, StallD, FlushD, FlushE, PCSrcD, pc_restart,
        output running, halted, cycle_count, stall_count
    );

    modport slave (
        output trigger, ext_stall, load_use, branch_taken_d, halt_d,
        input  StallF, StallD, FlushD, FlushE, PCSrcD, pc_restart,
        input  running, halted, cycle_count, stall_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - Fetch/decode front-end sequencer with hazard arbitration and perf counters.
module fetch_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic        clk,
    input  logic        reset,
    fetch_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RESTART,
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] stl_q, stl_d;
    logic             running_q, halted_q;

    logic stall_req;
    logic stall_f, stall_d_o, flush_d, flush_e, pc_src_d, pc_restart;

    assign stall_req = bus.ext_stall | bus.load_use;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cyc_d   = cyc_q;
        stl_d   = stl_q;
        case (state_q)
            S_IDLE: begin
                if (bus.trigger) begin
                    state_d = S_RUN;
                end
            end
            S_RESTART: begin
                cyc_d   = '0;
                stl_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cyc_q != CNT_MAX) begin
                    cyc_d = cyc_q + CNT_ONE;
                end
                if (stall_req) begin
                    if (stl_q != CNT_MAX) begin
                        stl_d = stl_q + CNT_ONE;
                    end
                end else if (bus.halt_d) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (cyc_q != CNT_MAX) begin
                    cyc_d = cyc_q + CNT_ONE;
                end
                // A memory stall freezes the drain so the bubbles still reach Execute.
                if (!bus.ext_stall) begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = S_HALTED;
                    end else begin
                        drain_d = drain_q + 4'd1;
                    end
                end
            end
            S_HALTED: begin
                if (bus.trigger) begin
                    state_d = S_RESTART;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            drain_q   <= '0;
            cyc_q     <= '0;
            stl_q     <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            cyc_q     <= cyc_d;
            stl_q     <= stl_d;
            running_q <= (state_d == S_RUN);
            halted_q  <= (state_d == S_HALTED);
        end
    end

    // Pipeline controls are combinational so a hazard acts in the cycle it is raised.
    always_comb begin
        stall_f    = 1'b0;
        stall_d_o  = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        pc_src_d   = 1'b0;
        pc_restart = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                stall_f   = 1'b1;
                stall_d_o = 1'b1;
                flush_d   = 1'b1;
                flush_e   = 1'b1;
            end
            S_RESTART: begin
                pc_restart = 1'b1;
                stall_d_o  = 1'b1;
                flush_d    = 1'b1;
                flush_e    = 1'b1;
            end
            S_RUN: begin
                if (stall_req) begin
                    stall_f   = 1'b1;
                    stall_d_o = 1'b1;
                    flush_e   = 1'b1;
                end else if (bus.halt_d) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end else if (bus.branch_taken_d) begin
                    pc_src_d = 1'b1;
                    flush_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                stall_f   = 1'b1;
                flush_d   = 1'b1;
                stall_d_o = stall_req;
                flush_e   = stall_req;
            end
            default: begin
                stall_f   = 1'b1;
                stall_d_o = 1'b1;
                flush_d   = 1'b1;
                flush_e   = 1'b1;
            end
        endcase
    end

    assign bus.StallF      = stall_f;
    assign bus.StallD      = stall_d_o;
    assign bus.FlushD      = flush_d;
    assign bus.FlushE      = flush_e;
    assign bus.PCSrcD      = pc_src_d;
    assign bus.pc_restart  = pc_restart;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.cycle_count = cyc_q;
    assign bus.stall_count = stl_q;
endmodule
